// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch front-panel bundle: raw buttons and overflow in,
// counter controls and status out.
interface stopwatch_ctrl_if;
  logic       btn_start_stop_n;
  logic       btn_lap_reset_n;
  logic       overflow_flag;
  logic       sw_start_stop_n;
  logic       sw_hold_n;
  logic       sw_clear_n;
  logic [2:0] state;
  logic       lap_led;

  modport master (
    output btn_start_stop_n,
    output btn_lap_reset_n,
    output overflow_flag,
    input  sw_start_stop_n,
    input  sw_hold_n,
    input  sw_clear_n,
    input  state,
    input  lap_led
  );

  modport slave (
    input  btn_start_stop_n,
    input  btn_lap_reset_n,
    input  overflow_flag,
    output sw_start_stop_n,
    output sw_hold_n,
    output sw_clear_n,
    output state,
    output lap_led
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch panel controller: button sync/debounce plus a Moore FSM
// driving the counter's start/stop, hold and clear controls.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CLEAR_CYCLES    = 4
) (
  input logic            CLK_50MHz,
  input logic            reset_n,
  stopwatch_ctrl_if.slave sw
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int CW = $clog2(CLEAR_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CL_LAST = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    OVF   = 3'd4,
    CLEAR = 3'd5
  } state_t;

  logic [1:0] raw;
  logic [1:0] press;
  logic       ovf_s1;
  logic       ovf_s2;

  assign raw = {sw.btn_lap_reset_n, sw.btn_start_stop_n};

  // Bit 0 is start/stop, bit 1 is lap/reset.
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic          s1;
    logic          s2;
    logic          acc;
    logic          ev;
    logic [DW-1:0] cnt;

    always_ff @(posedge CLK_50MHz or negedge reset_n) begin
      if (!reset_n) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        acc <= 1'b1;
        ev  <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        ev <= 1'b0;
        if (s2 == acc) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          acc <= s2;
          cnt <= '0;
          ev  <= acc;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[i] = ev;
  end

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      ovf_s1 <= 1'b0;
      ovf_s2 <= 1'b0;
    end else begin
      ovf_s1 <= sw.overflow_flag;
      ovf_s2 <= ovf_s1;
    end
  end

  logic          st_ev;
  logic          lap_ev;
  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] clr_cnt;
  logic          ss_n_d;
  logic          hold_n_d;
  logic          clr_n_d;
  logic          led_d;
  logic          ss_n_q;
  logic          hold_n_q;
  logic          clr_n_q;
  logic          led_q;

  assign st_ev  = press[0];
  assign lap_ev = press[1];

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= IDLE;
      clr_cnt  <= '0;
      ss_n_q   <= 1'b1;
      hold_n_q <= 1'b1;
      clr_n_q  <= 1'b1;
      led_q    <= 1'b0;
    end else begin
      cur      <= nxt;
      clr_cnt  <= (cur == CLEAR) ? clr_cnt + 1'b1 : '0;
      ss_n_q   <= ss_n_d;
      hold_n_q <= hold_n_d;
      clr_n_q  <= clr_n_d;
      led_q    <= led_d;
    end
  end

  // Overflow outranks presses while counting; start outranks lap.
  always_comb begin
    nxt = IDLE;
    case (cur)
      IDLE:    nxt = st_ev ? RUN : IDLE;
      RUN: begin
        nxt = RUN;
        if (ovf_s2)      nxt = OVF;
        else if (st_ev)  nxt = PAUSE;
        else if (lap_ev) nxt = LAP;
      end
      LAP: begin
        nxt = LAP;
        if (ovf_s2)      nxt = OVF;
        else if (st_ev)  nxt = PAUSE;
        else if (lap_ev) nxt = RUN;
      end
      PAUSE: begin
        nxt = PAUSE;
        if (st_ev)       nxt = RUN;
        else if (lap_ev) nxt = CLEAR;
      end
      OVF:     nxt = lap_ev ? CLEAR : OVF;
      CLEAR:   nxt = (clr_cnt == CL_LAST) ? IDLE : CLEAR;
      default: nxt = IDLE;
    endcase
  end

  // Decoded from the next state so the registered outputs track state.
  always_comb begin
    ss_n_d   = 1'b1;
    hold_n_d = 1'b1;
    clr_n_d  = 1'b1;
    led_d    = 1'b0;
    unique case (1'b1)
      (nxt == RUN): ss_n_d = 1'b0;
      (nxt == LAP): begin
        ss_n_d   = 1'b0;
        hold_n_d = 1'b0;
        led_d    = 1'b1;
      end
      (nxt == CLEAR): clr_n_d = 1'b0;
      default: ;
    endcase
  end

  assign sw.state           = cur;
  assign sw.sw_start_stop_n = ss_n_q;
  assign sw.sw_hold_n       = hold_n_q;
  assign sw.sw_clear_n      = clr_n_q;
  assign sw.lap_led         = led_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with short debounce and clear
// windows; hand-computed expectations checked by immediate asserts.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #10 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CLEAR_CYCLES(4)
  ) dut (
    .CLK_50MHz(clk),
    .reset_n(rst_n),
    .sw(sw_if)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [2:0] got,
                     input logic [2:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [2:0] st,
                         input logic ss, input logic hd,
                         input logic cl, input logic led);
    chk({tag, ".state"}, sw_if.state, st);
    chk({tag, ".ss_n"}, {2'b0, sw_if.sw_start_stop_n}, {2'b0, ss});
    chk({tag, ".hold_n"}, {2'b0, sw_if.sw_hold_n}, {2'b0, hd});
    chk({tag, ".clr_n"}, {2'b0, sw_if.sw_clear_n}, {2'b0, cl});
    chk({tag, ".led"}, {2'b0, sw_if.lap_led}, {2'b0, led});
  endtask

  // Hold 8 cycles (event at 6, state at 7), release, let release settle.
  task automatic press(input bit lap);
    if (lap) sw_if.btn_lap_reset_n = 1'b0;
    else     sw_if.btn_start_stop_n = 1'b0;
    cyc(8);
    sw_if.btn_lap_reset_n  = 1'b1;
    sw_if.btn_start_stop_n = 1'b1;
    cyc(8);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_if.btn_start_stop_n = 1'b1;
    sw_if.btn_lap_reset_n  = 1'b1;
    sw_if.overflow_flag    = 1'b0;
    cyc(3);
    chk_all("reset", 3'd0, 1, 1, 1, 0);
    rst_n = 1'b1;
    cyc(2);

    // Bounces: 3-low/1-high never reach four stable cycles
    for (int i = 0; i < 4; i++) begin
      sw_if.btn_start_stop_n = 1'b0;
      cyc(3);
      sw_if.btn_start_stop_n = 1'b1;
      cyc(1);
    end
    cyc(8);
    chk("bounce_idle", sw_if.state, 3'd0);

    // Clean press: event 6 cycles after the edge, state one later
    sw_if.btn_start_stop_n = 1'b0;
    cyc(6);
    chk("lat6_idle", sw_if.state, 3'd0);
    cyc(1);
    chk_all("lat7_run", 3'd1, 0, 1, 1, 0);
    cyc(13);
    sw_if.btn_start_stop_n = 1'b1;
    cyc(10);
    chk("release_run", sw_if.state, 3'd1);

    press(1'b1);
    chk_all("lap", 3'd3, 0, 0, 1, 1);
    press(1'b1);
    chk_all("lap_back", 3'd1, 0, 1, 1, 0);

    press(1'b0);
    chk_all("pause", 3'd2, 1, 1, 1, 0);
    sw_if.btn_lap_reset_n = 1'b0;
    cyc(7);
    chk_all("clear_first", 3'd5, 1, 1, 0, 0);
    cyc(3);
    chk_all("clear_last", 3'd5, 1, 1, 0, 0);
    cyc(1);
    chk_all("clear_done", 3'd0, 1, 1, 1, 0);
    sw_if.btn_lap_reset_n = 1'b1;
    cyc(8);

    // Overflow path
    press(1'b0);
    chk("run_again", sw_if.state, 3'd1);
    sw_if.overflow_flag = 1'b1;
    cyc(2);
    chk("ovf_sync", sw_if.state, 3'd1);
    cyc(1);
    chk_all("ovf", 3'd4, 1, 1, 1, 0);
    press(1'b0);
    chk("ovf_start_ign", sw_if.state, 3'd4);
    sw_if.btn_lap_reset_n = 1'b0;
    cyc(7);
    chk("ovf_clear", sw_if.state, 3'd5);
    cyc(4);
    chk_all("ovf_idle", 3'd0, 1, 1, 1, 0);
    sw_if.btn_lap_reset_n = 1'b1;
    cyc(4);
    press(1'b1);
    chk("idle_lap_ign", sw_if.state, 3'd0);
    sw_if.overflow_flag = 1'b0;
    cyc(4);

    // Overflow and start event land in the same cycle in RUN
    press(1'b0);
    chk("run_tie", sw_if.state, 3'd1);
    sw_if.btn_start_stop_n = 1'b0;
    cyc(4);
    sw_if.overflow_flag = 1'b1;
    cyc(3);
    chk("tie_ovf", sw_if.state, 3'd4);
    sw_if.btn_start_stop_n = 1'b1;
    sw_if.overflow_flag = 1'b0;
    cyc(8);
    press(1'b1);
    chk("tie_idle", sw_if.state, 3'd0);

    // Reset mid-CLEAR
    press(1'b0);
    press(1'b0);
    chk("pause2", sw_if.state, 3'd2);
    sw_if.btn_lap_reset_n = 1'b0;
    cyc(8);
    chk("mid_clear", sw_if.state, 3'd5);
    rst_n = 1'b0;
    #1;
    chk_all("rst_clear", 3'd0, 1, 1, 1, 0);
    sw_if.btn_lap_reset_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk_all("post_rst_clear", 3'd0, 1, 1, 1, 0);

    // Reset mid-debounce: pending press must vanish
    sw_if.btn_start_stop_n = 1'b0;
    cyc(4);
    sw_if.btn_start_stop_n = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all("rst_db", 3'd0, 1, 1, 1, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("post_rst_db", sw_if.state, 3'd0);

    // Button held through reset gives one press
    sw_if.btn_start_stop_n = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("held_wait", sw_if.state, 3'd0);
    cyc(1);
    chk("held_run", sw_if.state, 3'd1);
    sw_if.btn_start_stop_n = 1'b1;
    cyc(10);
    chk("held_once", sw_if.state, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
